// File: rtl/hsync_gen.sv
// Horizontal timing generator: hsync, active-pixel qualifier, pixel index,
// and an equal-width column split of the active region.
// All outputs are registered, one clock after the counter value they describe.
module hsync_gen #(
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned H_TOTAL  = 525,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned N_COLS   = 4,
    parameter int unsigned COL_IW   = 2,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              line,
    output logic              hsync,
    output logic              out,
    output logic [CNT_W-1:0]  pxl,
    output logic [COL_IW-1:0] col,
    output logic [CNT_W-1:0]  col_pxl,
    output logic              sol,
    output logic              eol
);

    localparam int unsigned A0 = H_SYNC + H_BP;
    localparam int unsigned A1 = A0 + H_ACTIVE - 1;
    localparam int unsigned CW = H_ACTIVE / N_COLS;

    localparam logic [CNT_W-1:0] A0_V    = CNT_W'(A0);
    localparam logic [CNT_W-1:0] A1_V    = CNT_W'(A1);
    localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_V  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] CW_LAST = CNT_W'(CW - 1);

    // Reject timing sets that cannot be represented or split evenly.
    if (A1 > H_TOTAL - 1) begin : g_err_active
        $error("hsync_gen: active region extends past end of line");
    end
    if (H_ACTIVE % N_COLS != 0) begin : g_err_cols
        $error("hsync_gen: H_ACTIVE not divisible by N_COLS");
    end
    if (H_TOTAL > 2 ** CNT_W) begin : g_err_width
        $error("hsync_gen: H_TOTAL does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    // Column tracker: describes the current cnt, valid whenever cnt is in the
    // active window, and kept running independent of line.
    logic [CNT_W-1:0]  trk_pxl;
    logic [COL_IW-1:0] trk_col;
    logic              in_act;

    // Next counter value and active-window decode for the current cnt/line.
    always_comb begin
        cnt_nxt = (cnt == LAST_V) ? '0 : cnt + CNT_W'(1);
        in_act  = line && (cnt >= A0_V) && (cnt <= A1_V);
    end

    // Counter, column tracker and registered outputs; en low freezes all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            trk_pxl <= '0;
            trk_col <= '0;
            hsync   <= ~SYNC_POL;
            out     <= 1'b0;
            pxl     <= '0;
            col     <= '0;
            col_pxl <= '0;
            sol     <= 1'b0;
            eol     <= 1'b0;
        end else if (en) begin
            cnt <= cnt_nxt;
            // Realign on entry to the active window so the pair never drifts.
            if (cnt_nxt == A0_V) begin
                trk_pxl <= '0;
                trk_col <= '0;
            end else if (trk_pxl == CW_LAST) begin
                trk_pxl <= '0;
                trk_col <= trk_col + COL_IW'(1);
            end else begin
                trk_pxl <= trk_pxl + CNT_W'(1);
            end
            hsync   <= (cnt < SYNC_V) ? SYNC_POL : ~SYNC_POL;
            out     <= in_act;
            pxl     <= in_act ? cnt - A0_V : '0;
            col     <= in_act ? trk_col : '0;
            col_pxl <= in_act ? trk_pxl : '0;
            sol     <= (cnt == '0);
            eol     <= line && (cnt == A1_V);
        end
    end

endmodule

// File: tb/tb_hsync_gen.sv
// Bench for hsync_gen: a default-timing instance and a 640x800 / 8-column
// active-high instance driven in lockstep and compared against an arithmetic
// model every cycle, plus a vector table and directed corner sequences.
module tb_hsync_gen;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic en   = 1'b1;
    logic line = 1'b1;

    logic       a_hsync, a_out, a_sol, a_eol;
    logic [9:0] a_pxl, a_col_pxl;
    logic [1:0] a_col;
    logic       b_hsync, b_out, b_sol, b_eol;
    logic [9:0] b_pxl, b_col_pxl;
    logic [2:0] b_col;

    hsync_gen dut_a (
        .clk(clk), .rst(rst), .en(en), .line(line),
        .hsync(a_hsync), .out(a_out), .pxl(a_pxl), .col(a_col),
        .col_pxl(a_col_pxl), .sol(a_sol), .eol(a_eol)
    );

    hsync_gen #(
        .CNT_W(10), .H_TOTAL(800), .H_SYNC(96), .H_BP(48), .H_ACTIVE(640),
        .N_COLS(8), .COL_IW(3), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .line(line),
        .hsync(b_hsync), .out(b_out), .pxl(b_pxl), .col(b_col),
        .col_pxl(b_col_pxl), .sol(b_sol), .eol(b_eol)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hsync;
        logic       out;
        logic [9:0] pxl;
        logic [3:0] col;
        logic [9:0] col_pxl;
        logic       sol;
        logic       eol;
    } exp_t;

    typedef struct {
        string name;
        int    cyc;
        bit    ln;
        exp_t  exp;
    } row_t;

    int   checks = 0;
    int   errors = 0;
    int   ma = 0;
    int   mb = 0;
    exp_t ea, eb, ga, gb;

    assign ga = {a_hsync, a_out, a_pxl, 2'b00, a_col, a_col_pxl, a_sol, a_eol};
    assign gb = {b_hsync, b_out, b_pxl, 1'b0, b_col, b_col_pxl, b_sol, b_eol};

    function automatic exp_t mk(bit h, bit o, int p, int c, int cp, bit s, bit e);
        exp_t r;
        r.hsync = h; r.out = o; r.pxl = 10'(p); r.col = 4'(c);
        r.col_pxl = 10'(cp); r.sol = s; r.eol = e;
        return r;
    endfunction

    function automatic exp_t rst_val(bit pol);
        return mk(!pol, 0, 0, 0, 0, 0, 0);
    endfunction

    // Outputs expected one clock after the counter sat at position c.
    function automatic exp_t ref_out(int c, bit ln, int hs, int hb, int ha, int nc, bit pol);
        int a0 = hs + hb;
        int a1 = a0 + ha - 1;
        int cw = ha / nc;
        bit act = ln && (c >= a0) && (c <= a1);
        return mk((c < hs) ? pol : !pol, act, act ? c - a0 : 0,
                  act ? (c - a0) / cw : 0, act ? (c - a0) % cw : 0,
                  c == 0, ln && (c == a1));
    endfunction

    task automatic check(string name, exp_t got, exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got hsync=%0b out=%0b pxl=%0d col=%0d col_pxl=%0d sol=%0b eol=%0b, expected hsync=%0b out=%0b pxl=%0d col=%0d col_pxl=%0d sol=%0b eol=%0b (t=%0t)",
                     name, got.hsync, got.out, got.pxl, got.col, got.col_pxl, got.sol,
                     got.eol, exp.hsync, exp.out, exp.pxl, exp.col, exp.col_pxl, exp.sol,
                     exp.eol, $time);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        ma = 0; mb = 0;
        ea = rst_val(1'b0);
        eb = rst_val(1'b1);
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (en) begin
            ea = ref_out(ma, line, 41, 2, 480, 4, 1'b0);
            ma = (ma + 1) % 525;
            eb = ref_out(mb, line, 96, 48, 640, 8, 1'b1);
            mb = (mb + 1) % 800;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_a", ga, ea);
        check("model_b", gb, eb);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("reset_a", ga, ea);
        check("reset_b", gb, eb);
        step();
        step();
        rst = 1'b0;
    endtask

    row_t rows[15];
    int   lo, hi, act, sols, first;

    initial begin
        // After cyc enabled edges from reset, outputs describe cnt = cyc-1.
        rows[0]  = '{"sol_start",    1,   1'b1, mk(0, 0, 0,   0, 0,   1, 0)};
        rows[1]  = '{"sync_last",    41,  1'b1, mk(0, 0, 0,   0, 0,   0, 0)};
        rows[2]  = '{"sync_end",     42,  1'b1, mk(1, 0, 0,   0, 0,   0, 0)};
        rows[3]  = '{"back_porch",   43,  1'b1, mk(1, 0, 0,   0, 0,   0, 0)};
        rows[4]  = '{"first_active", 44,  1'b1, mk(1, 1, 0,   0, 0,   0, 0)};
        rows[5]  = '{"col0_end",     163, 1'b1, mk(1, 1, 119, 0, 119, 0, 0)};
        rows[6]  = '{"col1_start",   164, 1'b1, mk(1, 1, 120, 1, 0,   0, 0)};
        rows[7]  = '{"col2_start",   284, 1'b1, mk(1, 1, 240, 2, 0,   0, 0)};
        rows[8]  = '{"col3_start",   404, 1'b1, mk(1, 1, 360, 3, 0,   0, 0)};
        rows[9]  = '{"last_active",  523, 1'b1, mk(1, 1, 479, 3, 119, 0, 1)};
        rows[10] = '{"front_porch",  524, 1'b1, mk(1, 0, 0,   0, 0,   0, 0)};
        rows[11] = '{"line_end",     525, 1'b1, mk(1, 0, 0,   0, 0,   0, 0)};
        rows[12] = '{"wrap_sol",     526, 1'b1, mk(0, 0, 0,   0, 0,   1, 0)};
        rows[13] = '{"line_low_act", 200, 1'b0, mk(1, 0, 0,   0, 0,   0, 0)};
        rows[14] = '{"line_low_eol", 523, 1'b0, mk(1, 0, 0,   0, 0,   0, 0)};

        #2;
        for (int i = 0; i < 15; i++) begin
            en = 1'b1;
            line = rows[i].ln;
            do_reset();
            repeat (rows[i].cyc) step();
            check(rows[i].name, ga, rows[i].exp);
        end

        // Two full lines: sync width, active length, period.
        line = 1'b1; en = 1'b1;
        do_reset();
        lo = 0; act = 0; sols = 0;
        repeat (1050) begin
            step();
            if (!a_hsync) lo++;
            if (a_out) act++;
            if (a_sol) sols++;
        end
        check_int("sync_clocks_2lines", lo, 82);
        check_int("active_clocks_2lines", act, 960);
        check_int("sol_count_2lines", sols, 2);

        // line dropped for pxl 200..299, restored at 300 with aligned columns.
        do_reset();
        repeat (243) step();
        check("pre_drop", ga, mk(1, 1, 199, 1, 79, 0, 0));
        line = 1'b0;
        repeat (100) step();
        check("line_dropped", ga, mk(1, 0, 0, 0, 0, 0, 0));
        line = 1'b1;
        step();
        check("line_restored", ga, mk(1, 1, 300, 2, 60, 0, 0));

        // en low at cnt 100 and again at cnt 524 (wrap cycle).
        do_reset();
        repeat (100) step();
        en = 1'b0;
        repeat (10) step();
        check("frozen_100", ga, mk(1, 1, 56, 0, 56, 0, 0));
        en = 1'b1;
        repeat (424) step();
        en = 1'b0;
        repeat (10) step();
        check("frozen_wrap", ga, mk(1, 0, 0, 0, 0, 0, 0));
        en = 1'b1;
        step();
        check("resume_wrap", ga, mk(1, 0, 0, 0, 0, 0, 0));
        step();
        check("resume_sol", ga, mk(0, 0, 0, 0, 0, 1, 0));
        lo = 1;
        repeat (524) begin
            step();
            if (!a_hsync) lo++;
        end
        check_int("sync_clocks_after_freeze", lo, 41);

        // Asynchronous reset between edges at pxl 250.
        do_reset();
        repeat (294) step();
        check("pre_rst", ga, mk(1, 1, 250, 2, 10, 0, 0));
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_a", ga, rst_val(1'b0));
        check("async_rst_b", gb, rst_val(1'b1));
        step();
        rst = 1'b0;
        step();
        check("post_rst_sol", ga, mk(0, 0, 0, 0, 0, 1, 0));
        lo = 1;
        repeat (59) begin
            step();
            if (!a_hsync) lo++;
        end
        check_int("post_rst_sync_clocks", lo, 41);

        // Second timing set: sync high 96, first active at cnt 144.
        do_reset();
        hi = 0; first = -1;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (b_hsync) hi++;
            if (b_out && first < 0) first = i;
        end
        check_int("b_sync_clocks", hi, 96);
        check_int("b_first_active_edge", first, 145);

        // Random en/line/rst against the model.
        do_reset();
        repeat (4000) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) line = ~line;
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
